key_debounce: RTL and testbench

- Upstream conditioning stage for the d_flip_flop block. It turns a raw, asynchronous, bouncing push-button input into a clean synchronous level that drives d_flip_flop.led_in.
- Also produces single-cycle press and release pulses for downstream control logic.
- Structure: double-flop synchronizer, then a 4-state debounce FSM with a stability counter.

---
 rtl/key_debounce.sv | 122 ++++++++++++
 tb/tb_key_debounce.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// Push-button conditioner: synchronizer chain, then a 4-state debounce FSM with press/release pulses.
// Optional build macro KEY_ACTIVE_LOW_EN: the button pulls the pin low when pressed.
module key_debounce #(
  parameter int CNT_MAX     = 999_999,
  parameter int SYNC_STAGES = 2
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);

`ifdef KEY_ACTIVE_LOW_EN
  localparam logic IDLE_RAW = 1'b1;
`else
  localparam logic IDLE_RAW = 1'b0;
`endif

  typedef enum logic [1:0] {
    STABLE_LO,
    WAIT_HI,
    STABLE_HI,
    WAIT_LO
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   key_s;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;

  // The chain idles at the released pin level, so a button held through reset
  // still has to propagate the full chain depth before the FSM sees it.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], key_in};
  end

  // Pressed = pin differs from its idle level; identical to inverting at the input.
  assign key_s = sync_q[SYNC_STAGES-1] ^ IDLE_RAW;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      STABLE_LO: begin
        if (key_s) begin
          state_d = WAIT_HI;
          cnt_d   = '0;
        end
      end
      WAIT_HI: begin
        if (!key_s) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = STABLE_HI;
          level_d = 1'b1;
          press_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STABLE_HI: begin
        if (!key_s) begin
          state_d = WAIT_LO;
          cnt_d   = '0;
        end
      end
      WAIT_LO: begin
        if (key_s) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d   = STABLE_LO;
          level_d   = 1'b0;
          release_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync_q    <= {SYNC_STAGES{IDLE_RAW}};
      state_q   <= STABLE_LO;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: stimulus queues expected pulse edges, a monitor checks every cycle.
`timescale 1ns/1ps
module tb_key_debounce;

  localparam int CNT_MAX = 9;
  localparam int SYNC    = 2;
  localparam int LAT     = SYNC + CNT_MAX + 1;

`ifdef KEY_ACTIVE_LOW_EN
  localparam logic ACT_LOW = 1'b1;
`else
  localparam logic ACT_LOW = 1'b0;
`endif

  logic sys_clk = 1'b0;
  logic sys_rst;
  logic key_in;
  logic key_level;
  logic key_press;
  logic key_release;

  typedef struct {
    int edge_no;
    bit press;
  } ev_t;

  ev_t exp_q[$];
  int  edge_n      = 0;
  bit  done        = 1'b0;
  int  tests       = 0;
  int  fails       = 0;
  bit  model_level = 1'b0;

  key_debounce #(
    .CNT_MAX    (CNT_MAX),
    .SYNC_STAGES(SYNC)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .key_in     (key_in),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release)
  );

  always #10 sys_clk = ~sys_clk;

  always @(posedge sys_clk) edge_n <= edge_n + 1;

  // Inputs change 5 ns after a rising edge; the next edge is edge_n + 1.
  task automatic wait_edges(input int n);
    repeat (n) @(posedge sys_clk);
    #5;
  endtask

  task automatic set_key(input bit pressed);
    key_in = pressed ^ ACT_LOW;
  endtask

  task automatic expect_ev(input int after, input bit press);
    ev_t e;
    e.edge_no = edge_n + after;
    e.press   = press;
    exp_q.push_back(e);
  endtask

  initial begin
    sys_rst = 1'b1;
    set_key(1'b0);
    wait_edges(2);
    sys_rst = 1'b0;
    wait_edges(3);

    // Reset asserted mid-cycle with the button held; press follows the full latency.
    set_key(1'b1);
    sys_rst = 1'b1;
    wait_edges(3);
    sys_rst = 1'b0;
    expect_ev(1 + LAT, 1'b1);
    wait_edges(LAT + 6);
    set_key(1'b0);
    expect_ev(1 + LAT, 1'b0);
    wait_edges(LAT + 6);

    // Clean press held 30 cycles, then release.
    set_key(1'b1);
    expect_ev(1 + LAT, 1'b1);
    wait_edges(30);
    set_key(1'b0);
    expect_ev(1 + LAT, 1'b0);
    wait_edges(LAT + 6);

    // Bounce every 3 cycles, finishing high.
    for (int i = 0; i < 7; i++) begin
      set_key((i % 2) == 0);
      if (i == 6) expect_ev(1 + LAT, 1'b1);
      wait_edges(3);
    end
    wait_edges(LAT + 4);
    set_key(1'b0);
    expect_ev(1 + LAT, 1'b0);
    wait_edges(LAT + 6);

    // Window boundary: one sample short is rejected, the exact window is accepted.
    set_key(1'b1);
    wait_edges(CNT_MAX + 1);
    set_key(1'b0);
    wait_edges(LAT + 6);
    set_key(1'b1);
    expect_ev(1 + LAT, 1'b1);
    wait_edges(CNT_MAX + 2);
    set_key(1'b0);
    expect_ev(1 + LAT, 1'b0);
    wait_edges(LAT + 6);

    // Reset while counting in WAIT_HI (cnt = 5), button still held afterwards.
    set_key(1'b1);
    wait_edges(8);
    sys_rst = 1'b1;
    wait_edges(3);
    sys_rst = 1'b0;
    expect_ev(1 + LAT, 1'b1);
    wait_edges(LAT + 6);
    set_key(1'b0);
    expect_ev(1 + LAT, 1'b0);
    wait_edges(LAT + 6);

    // Reset lands in the very cycle the press pulse is high.
    set_key(1'b1);
    wait_edges(1 + LAT);
    sys_rst = 1'b1;
    wait_edges(2);
    sys_rst = 1'b0;
    expect_ev(1 + LAT, 1'b1);
    wait_edges(LAT + 6);
    set_key(1'b0);
    expect_ev(1 + LAT, 1'b0);
    wait_edges(LAT + 6);

    done = 1'b1;
  end

  always @(negedge sys_clk) begin : monitor
    bit ep;
    bit er;
    if (done) begin
      tests++;
      if (exp_q.size() != 0) begin
        fails++;
        $display("FAIL pending_events: %0d left, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end else if (sys_rst) begin
      tests++;
      if ({key_level, key_press, key_release} !== 3'b000) begin
        fails++;
        $display("FAIL reset_outputs edge %0d: got %b required 000", edge_n,
                 {key_level, key_press, key_release});
      end
      exp_q.delete();
      model_level = 1'b0;
    end else begin
      while (exp_q.size() > 0 && exp_q[0].edge_no < edge_n) begin
        tests++;
        fails++;
        $display("FAIL missed_pulse: edge %0d passed, required %s", exp_q[0].edge_no,
                 exp_q[0].press ? "press" : "release");
        void'(exp_q.pop_front());
      end
      ep = 1'b0;
      er = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].edge_no == edge_n) begin
        ep          = exp_q[0].press;
        er          = !exp_q[0].press;
        model_level = exp_q[0].press;
        void'(exp_q.pop_front());
      end
      tests++;
      if (key_press !== ep) begin
        fails++;
        $display("FAIL key_press edge %0d: got %b required %b", edge_n, key_press, ep);
      end
      tests++;
      if (key_release !== er) begin
        fails++;
        $display("FAIL key_release edge %0d: got %b required %b", edge_n, key_release, er);
      end
      tests++;
      if (key_level !== model_level) begin
        fails++;
        $display("FAIL key_level edge %0d: got %b required %b", edge_n, key_level, model_level);
      end
    end
  end

  initial begin
    #60000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

endmodule
